sort_ctrl_fsm: RTL and testbench



---
 rtl/sort_pkg.sv | 42 ++++
 rtl/sort_ctrl_fsm.sv | 214 +++++++++++++++++++++
 tb/tb_sort_ctrl_fsm.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the selection-sort controller: FSM state encoding and
// the select codes driven towards the sort datapath.
package sort_pkg;

    // One state per controller step; encoding is left to the tools.
    typedef enum logic [4:0] {
        S_IDLE,
        S_INIT,
        S_SETTLE,
        S_RD_I,
        S_WT_I,
        S_RD_J,
        S_WT_J,
        S_CMP,
        S_RD_MIN,
        S_WT_MIN,
        S_NEXT_J,
        S_RD_KEY,
        S_WT_KEY,
        S_WR_I,
        S_WT_WR_I,
        S_WR_MIN,
        S_WT_WR_MIN,
        S_NEXT_I,
        S_DONE
    } sort_state_e;

    // RAM address select
    localparam logic [1:0] SEL_ADDR_I   = 2'b10;
    localparam logic [1:0] SEL_ADDR_MIN = 2'b01;
    localparam logic [1:0] SEL_ADDR_J   = 2'b00;

    // Read-capture target
    localparam logic [1:0] SEL_RD_MIN  = 2'b01;
    localparam logic [1:0] SEL_RD_DATA = 2'b00;
    localparam logic [1:0] SEL_RD_KEY  = 2'b11;

    // Write data source
    localparam logic SEL_WR_MIN = 1'b1;
    localparam logic SEL_WR_KEY = 1'b0;

endpackage

// File: rtl/sort_ctrl_fsm.sv
// Control FSM for the in-place selection-sort engine.
// Inputs : i_clk, i_rst (sync, active-high), i_start pulse, i_num_elems,
//          datapath status i_comp_less, i_valid_rd, i_valid_wr, i_done_j,
//          i_done_sort.
// Outputs: RAM requests o_rd_en/o_wr_en, selects o_sel_addr/o_sel_data_rd/
//          o_sel_data_wr, index controls o_start_i/o_update_i/o_update_j/
//          o_update_min, status o_busy/o_done. Every output is a flop.
module sort_ctrl_fsm
    import sort_pkg::*;
#(
    parameter int unsigned SIZE_ADDR = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [SIZE_ADDR-1:0] i_num_elems,
    input  logic                 i_comp_less,
    input  logic                 i_valid_rd,
    input  logic                 i_valid_wr,
    input  logic                 i_done_j,
    input  logic                 i_done_sort,
    output logic                 o_rd_en,
    output logic                 o_wr_en,
    output logic [1:0]           o_sel_addr,
    output logic [1:0]           o_sel_data_rd,
    output logic                 o_sel_data_wr,
    output logic                 o_start_i,
    output logic                 o_update_i,
    output logic                 o_update_j,
    output logic                 o_update_min,
    output logic                 o_busy,
    output logic                 o_done
);

    sort_state_e          state_q;
    logic [SIZE_ADDR-1:0] num_q;
    logic                 rd_en_q;
    logic                 wr_en_q;
    logic [1:0]           sel_addr_q;
    logic [1:0]           sel_data_rd_q;
    logic                 sel_data_wr_q;
    logic                 start_i_q;
    logic                 update_i_q;
    logic                 update_j_q;
    logic                 update_min_q;
    logic                 busy_q;
    logic                 done_q;

    // State register and registered output decode. Each output is set on the
    // transition into the state it belongs to, so it is valid for exactly
    // that state's cycle. Selects are only written when a request is issued
    // and therefore hold through the following wait state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= S_IDLE;
            num_q         <= '0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            sel_addr_q    <= 2'b00;
            sel_data_rd_q <= 2'b00;
            sel_data_wr_q <= 1'b0;
            start_i_q     <= 1'b0;
            update_i_q    <= 1'b0;
            update_j_q    <= 1'b0;
            update_min_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Pulses default low every cycle
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            start_i_q    <= 1'b0;
            update_i_q   <= 1'b0;
            update_j_q   <= 1'b0;
            update_min_q <= 1'b0;

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        state_q   <= S_INIT;
                        num_q     <= i_num_elems;
                        start_i_q <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end

                S_INIT: state_q <= S_SETTLE;

                // j/min have reloaded; fewer than two elements is sorted already
                S_SETTLE: begin
                    if (i_done_sort || (num_q <= SIZE_ADDR'(1))) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= S_RD_I;
                        rd_en_q       <= 1'b1;
                        sel_addr_q    <= SEL_ADDR_I;
                        sel_data_rd_q <= SEL_RD_MIN;
                    end
                end

                S_RD_I: state_q <= S_WT_I;

                S_WT_I: begin
                    if (i_valid_rd) begin
                        state_q       <= S_RD_J;
                        rd_en_q       <= 1'b1;
                        sel_addr_q    <= SEL_ADDR_J;
                        sel_data_rd_q <= SEL_RD_DATA;
                    end
                end

                S_RD_J: state_q <= S_WT_J;

                S_WT_J: begin
                    if (i_valid_rd) begin
                        state_q <= S_CMP;
                    end
                end

                // j is stable here, so i_done_j already tells whether NEXT_J
                // will advance j; the update pulse is then ready in NEXT_J.
                S_CMP: begin
                    if (i_comp_less) begin
                        state_q       <= S_RD_MIN;
                        update_min_q  <= 1'b1;
                        rd_en_q       <= 1'b1;
                        sel_addr_q    <= SEL_ADDR_MIN;
                        sel_data_rd_q <= SEL_RD_MIN;
                    end else begin
                        state_q    <= S_NEXT_J;
                        update_j_q <= ~i_done_j;
                    end
                end

                S_RD_MIN: state_q <= S_WT_MIN;

                S_WT_MIN: begin
                    if (i_valid_rd) begin
                        state_q    <= S_NEXT_J;
                        update_j_q <= ~i_done_j;
                    end
                end

                S_NEXT_J: begin
                    rd_en_q <= 1'b1;
                    if (i_done_j) begin
                        state_q       <= S_RD_KEY;
                        sel_addr_q    <= SEL_ADDR_I;
                        sel_data_rd_q <= SEL_RD_KEY;
                    end else begin
                        state_q       <= S_RD_J;
                        sel_addr_q    <= SEL_ADDR_J;
                        sel_data_rd_q <= SEL_RD_DATA;
                    end
                end

                S_RD_KEY: state_q <= S_WT_KEY;

                S_WT_KEY: begin
                    if (i_valid_rd) begin
                        state_q       <= S_WR_I;
                        wr_en_q       <= 1'b1;
                        sel_addr_q    <= SEL_ADDR_I;
                        sel_data_wr_q <= SEL_WR_MIN;
                    end
                end

                S_WR_I: state_q <= S_WT_WR_I;

                S_WT_WR_I: begin
                    if (i_valid_wr) begin
                        state_q       <= S_WR_MIN;
                        wr_en_q       <= 1'b1;
                        sel_addr_q    <= SEL_ADDR_MIN;
                        sel_data_wr_q <= SEL_WR_KEY;
                    end
                end

                S_WR_MIN: state_q <= S_WT_WR_MIN;

                S_WT_WR_MIN: begin
                    if (i_valid_wr) begin
                        state_q    <= S_NEXT_I;
                        update_i_q <= 1'b1;
                    end
                end

                S_NEXT_I: state_q <= S_SETTLE;

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_rd_en       = rd_en_q;
    assign o_wr_en       = wr_en_q;
    assign o_sel_addr    = sel_addr_q;
    assign o_sel_data_rd = sel_data_rd_q;
    assign o_sel_data_wr = sel_data_wr_q;
    assign o_start_i     = start_i_q;
    assign o_update_i    = update_i_q;
    assign o_update_j    = update_j_q;
    assign o_update_min  = update_min_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_sort_ctrl_fsm.sv
// Bench for sort_ctrl_fsm: a behavioural datapath + RAM closes the loop, a
// vector table of whole sorts is checked, plus hand-written corner sequences.
module tb_sort_ctrl_fsm;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [7:0] i_num_elems;
    logic       i_comp_less;
    logic       i_valid_rd;
    logic       i_valid_wr;
    logic       i_done_j;
    logic       i_done_sort;
    logic       o_rd_en;
    logic       o_wr_en;
    logic [1:0] o_sel_addr;
    logic [1:0] o_sel_data_rd;
    logic       o_sel_data_wr;
    logic       o_start_i;
    logic       o_update_i;
    logic       o_update_j;
    logic       o_update_min;
    logic       o_busy;
    logic       o_done;

    always #5 clk = ~clk;

    sort_ctrl_fsm #(.SIZE_ADDR(8)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_num_elems  (i_num_elems),
        .i_comp_less  (i_comp_less),
        .i_valid_rd   (i_valid_rd),
        .i_valid_wr   (i_valid_wr),
        .i_done_j     (i_done_j),
        .i_done_sort  (i_done_sort),
        .o_rd_en      (o_rd_en),
        .o_wr_en      (o_wr_en),
        .o_sel_addr   (o_sel_addr),
        .o_sel_data_rd(o_sel_data_rd),
        .o_sel_data_wr(o_sel_data_wr),
        .o_start_i    (o_start_i),
        .o_update_i   (o_update_i),
        .o_update_j   (o_update_j),
        .o_update_min (o_update_min),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // ---------------- behavioural datapath + RAM ----------------
    logic [7:0] mem      [4];
    logic [7:0] init_mem [4];
    logic [7:0] ri, rj, rmin;
    logic       reload;
    logic [7:0] t_min, t_data, t_key;
    int         rd_cnt = 0, wr_cnt = 0;
    int         lat    = 1;
    int         n_cfg  = 0;
    logic       ld     = 1'b0;
    logic       force_vrd = 1'b0;
    int         upd_min_n = 0, wr_n = 0, rd_n = 0, start_n = 0;
    int         dbl_n = 0;
    logic       rd_prev = 1'b0, wr_prev = 1'b0;
    logic       model_vrd;
    logic [1:0] addr;

    assign model_vrd   = (rd_cnt == 1);
    assign i_valid_rd  = model_vrd | force_vrd;
    assign i_valid_wr  = (wr_cnt == 1);
    assign i_comp_less = (t_data < t_min);
    assign i_done_j    = (int'(rj) == n_cfg - 1);
    assign i_done_sort = (n_cfg <= 1) || (int'(ri) == n_cfg - 1);
    // Address mux is live; RAM uses it when the data returns
    assign addr = (o_sel_addr == 2'b10) ? ri[1:0] :
                  (o_sel_addr == 2'b01) ? rmin[1:0] : rj[1:0];

    always @(posedge clk) begin
        if (ld) begin
            for (int k = 0; k < 4; k++) mem[k] <= init_mem[k];
            rd_cnt <= 0; wr_cnt <= 0;
            upd_min_n <= 0; wr_n <= 0; rd_n <= 0; start_n <= 0; dbl_n <= 0;
            rd_prev <= 1'b0; wr_prev <= 1'b0;
        end else begin
            if (o_start_i) begin
                ri <= 8'd0; reload <= 1'b1; start_n <= start_n + 1;
            end else if (o_update_i) begin
                ri <= ri + 8'd1; reload <= 1'b1;
            end else begin
                reload <= 1'b0;
            end
            if (reload) begin
                rj <= ri + 8'd1; rmin <= ri;
            end else begin
                if (o_update_j) rj <= rj + 8'd1;
                if (o_update_min) begin
                    rmin <= rj; upd_min_n <= upd_min_n + 1;
                end
            end
            if (o_rd_en) begin
                rd_cnt <= lat; rd_n <= rd_n + 1;
            end else if (rd_cnt != 0) begin
                rd_cnt <= rd_cnt - 1;
            end
            if (model_vrd) begin
                case (o_sel_data_rd)
                    2'b01:   t_min  <= mem[addr];
                    2'b00:   t_data <= mem[addr];
                    2'b11:   t_key  <= mem[addr];
                    default: ;
                endcase
            end
            if (o_wr_en) begin
                wr_cnt <= lat; wr_n <= wr_n + 1;
            end else if (wr_cnt != 0) begin
                wr_cnt <= wr_cnt - 1;
            end
            if (i_valid_wr) mem[addr] <= o_sel_data_wr ? t_min : t_key;
            if ((o_rd_en && rd_prev) || (o_wr_en && wr_prev)) dbl_n <= dbl_n + 1;
            rd_prev <= o_rd_en;
            wr_prev <= o_wr_en;
        end
    end

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int outs_all();
        return int'({o_rd_en, o_wr_en, o_sel_addr, o_sel_data_rd, o_sel_data_wr,
                     o_start_i, o_update_i, o_update_j, o_update_min, o_busy, o_done});
    endfunction

    task automatic load(input logic [3:0][7:0] init, input int n, input int l);
        for (int k = 0; k < 4; k++) init_mem[k] = init[k];
        n_cfg = n;
        lat   = l;
        ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int n);
        i_num_elems = 8'(n);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int c;
        c = 0;
        while (!o_done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_in_time"}, int'(o_done), 1);
    endtask

    task automatic wait_wr_i(output bit ok);
        int c;
        c = 0;
        while (!(o_wr_en && o_sel_addr == 2'b10) && c < 500) begin
            @(negedge clk);
            c++;
        end
        ok = (o_wr_en && o_sel_addr == 2'b10);
    endtask

    typedef struct {
        logic [3:0][7:0] init;
        int              n;
        int              l;
        logic [3:0][7:0] exp;
        int              upd;
        int              wr;
        int              rd;
    } vec_t;

    vec_t vecs [6];

    initial begin
        bit ok;
        int c;

        // element k of the RAM is byte k of init/exp
        vecs[0] = '{32'h09020103, 3, 2, 32'h09030201, 2, 4,  9};
        vecs[1] = '{32'h04030201, 4, 1, 32'h04030201, 0, 6, 12};
        vecs[2] = '{32'h01020304, 4, 1, 32'h04030201, 4, 6, 16};
        vecs[3] = '{32'h07010202, 3, 3, 32'h07020201, 1, 4,  8};
        vecs[4] = '{32'h08070605, 1, 1, 32'h08070605, 0, 0,  0};
        vecs[5] = '{32'h08070605, 0, 2, 32'h08070605, 0, 0,  0};

        i_rst = 1'b1;
        i_start = 1'b0;
        i_num_elems = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_all(), 0);
        i_rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs_all(), 0);

        // Reset while RD_J is issuing its read
        load(vecs[0].init, 3, 2);
        pulse_start(3);
        c = 0;
        while (!(o_rd_en && o_sel_addr == 2'b00) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reached_rd_j", int'(o_rd_en && o_sel_addr == 2'b00), 1);
        i_rst = 1'b1;
        @(negedge clk);
        chk("midsort_reset_outputs", outs_all(), 0);
        i_rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("after_reset_idle", outs_all(), 0);

        // n = 1: INIT, SETTLE, DONE with no RAM traffic
        load(vecs[4].init, 1, 1);
        pulse_start(1);
        chk("n1_init_start_i", int'(o_start_i), 1);
        chk("n1_init_busy", int'(o_busy), 1);
        chk("n1_init_done", int'(o_done), 0);
        @(negedge clk);
        chk("n1_settle_done", int'(o_done), 0);
        @(negedge clk);
        chk("n1_done_at_3", int'(o_done), 1);
        chk("n1_busy_low", int'(o_busy), 0);
        chk("n1_reads", rd_n, 0);
        chk("n1_writes", wr_n, 0);

        // Start while busy is ignored
        load(vecs[0].init, 3, 2);
        pulse_start(3);
        repeat (8) @(negedge clk);
        pulse_start(1);
        wait_done("busy_start");
        chk("busy_start_inits", start_n, 1);
        chk("busy_start_upd_min", upd_min_n, 2);
        for (int k = 0; k < 4; k++)
            chk($sformatf("busy_start_mem%0d", k), int'(mem[k]), int'(vecs[0].exp[k]));

        // Spurious read-valid while waiting for a write
        load(vecs[1].init, 4, 3);
        pulse_start(4);
        wait_wr_i(ok);
        chk("reached_wr_i", int'(ok), 1);
        force_vrd = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            chk($sformatf("spurious_hold_wr_t%0d", t), int'(o_wr_en), 0);
        end
        force_vrd = 1'b0;
        @(negedge clk);
        chk("spurious_wr_min_issued", int'(o_wr_en), 1);
        chk("spurious_wr_min_sel", int'(o_sel_addr), 1);
        wait_done("spurious");
        for (int k = 0; k < 4; k++)
            chk($sformatf("spurious_mem%0d", k), int'(mem[k]), int'(vecs[1].exp[k]));

        // Table of complete sorts, each started from DONE
        for (int v = 0; v < 6; v++) begin
            load(vecs[v].init, vecs[v].n, vecs[v].l);
            pulse_start(vecs[v].n);
            chk($sformatf("v%0d_start_i", v), int'(o_start_i), 1);
            chk($sformatf("v%0d_done_cleared", v), int'(o_done), 0);
            wait_done($sformatf("v%0d", v));
            chk($sformatf("v%0d_busy", v), int'(o_busy), 0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("v%0d_mem%0d", v, k), int'(mem[k]), int'(vecs[v].exp[k]));
            chk($sformatf("v%0d_upd_min", v), upd_min_n, vecs[v].upd);
            chk($sformatf("v%0d_writes", v), wr_n, vecs[v].wr);
            chk($sformatf("v%0d_reads", v), rd_n, vecs[v].rd);
            chk($sformatf("v%0d_pulse_width", v), dbl_n, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
